// File: rtl/sound_arbiter_pkg.sv
// Shared sound types, FSM states and per-sound lookup tables.
package sound_arbiter_pkg;

  typedef enum logic [2:0] {
    SND_NONE,
    SND_CHOMP,
    SND_EAT_GHOST,
    SND_DEATH,
    SND_INTRO
  } sound_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  localparam int NUM_SOUNDS = 4;
  localparam int MAX_SOUND_FRAMES = 240;

  localparam sound_t SOUND_MAP [NUM_SOUNDS] = '{
    SND_CHOMP, SND_EAT_GHOST, SND_DEATH, SND_INTRO
  };

  localparam int SOUND_FRAMES [NUM_SOUNDS] = '{
    8, 30, 90, 240
  };

  // Requesters beyond the table reuse the last entry.
  function automatic int clamp_idx(input int idx);
    return (idx < NUM_SOUNDS) ? idx : NUM_SOUNDS - 1;
  endfunction

  function automatic sound_t sound_of(input int idx);
    return SOUND_MAP[clamp_idx(idx)];
  endfunction

  function automatic int frames_of(input int idx);
    return SOUND_FRAMES[clamp_idx(idx)];
  endfunction

endpackage

// File: rtl/sound_arbiter_prio_encoder.sv
// Highest-index-wins priority encoder with a valid flag.
module prio_encoder #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Priority sound arbiter with frame-timed playback and a silent gap.
// Define SOUND_QUEUE_EN to keep lower-priority requests queued.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_FRAMES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               frame_stb,
  input  logic [NUM_REQ-1:0] req,
  output sound_t             sound_type,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXF = (GAP_FRAMES > MAX_SOUND_FRAMES) ?
                        GAP_FRAMES : MAX_SOUND_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_FRAMES);

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      cur_q;
  logic [NUM_REQ-1:0] pend_q;
  logic [NUM_REQ-1:0] pend_d;
  logic [NUM_REQ-1:0] grant_q;
  sound_t             snd_q;

  logic [NUM_REQ-1:0] act;
  logic [IW-1:0]      cand;
  logic               cand_v;
  logic               start;

  assign act = pend_q | req;

  prio_encoder #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_prio (
    .req_i   (act),
    .idx_o   (cand),
    .valid_o (cand_v)
  );

`ifndef SOUND_QUEUE_EN
  logic [NUM_REQ-1:0] low_mask;
  assign low_mask = (NUM_REQ'(1) << cur_q) - NUM_REQ'(1);
`endif

  // Start covers first play, preemption and retrigger alike.
  always_comb begin
    start = 1'b0;
    unique case (state_q)
      IDLE:    start = cand_v;
      PLAY:    start = cand_v && (cand > cur_q || req[cur_q]);
      default: start = 1'b0;
    endcase
    start = start & en;
  end

  always_comb begin
    pend_d = act;
`ifndef SOUND_QUEUE_EN
    if (state_q == PLAY) pend_d = pend_d & ~low_mask;
`endif
    if (start) pend_d[cand] = 1'b0;
    if (!en) pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      pend_q  <= '0;
      grant_q <= '0;
      snd_q   <= SND_NONE;
    end else begin
      pend_q  <= pend_d;
      grant_q <= '0;
      if (!en) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        snd_q   <= SND_NONE;
      end else if (start) begin
        state_q       <= PLAY;
        cur_q         <= cand;
        cnt_q         <= CW'(frames_of(int'(cand)));
        snd_q         <= sound_of(int'(cand));
        grant_q[cand] <= 1'b1;
      end else if (frame_stb) begin
        unique case (state_q)
          PLAY: begin
            if (cnt_q == CW'(1)) begin
              snd_q <= SND_NONE;
              if (GAP_FRAMES == 0) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                state_q <= GAP;
                cnt_q   <= GAP_LD;
              end
            end else if (cnt_q != '0) begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          GAP: begin
            if (cnt_q <= CW'(1)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sound_type = snd_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter: vector table, corner sequences, random vs model.
module tb_sound_arbiter;
  import sound_arbiter_pkg::*;

  localparam int NR   = 4;
  localparam int GAPF = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          frame_stb;
  logic [NR-1:0] req;
  sound_t        sound_type;
  logic [NR-1:0] grant;
  logic          busy;

  sound_arbiter #(.NUM_REQ(NR), .GAP_FRAMES(GAPF)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_stb  (frame_stb),
    .req        (req),
    .sound_type (sound_type),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  sound_t snd_tab [NR] = '{SND_CHOMP, SND_EAT_GHOST, SND_DEATH, SND_INTRO};
  int     len_tab [NR] = '{8, 30, 90, 240};

  // Reference: which sound plays, frames left, gap frames left, pending set.
  int            m_play = -1;
  int            m_left = 0;
  int            m_gap  = 0;
  bit [NR-1:0]   m_pend = '0;
  logic [NR-1:0] m_grant = '0;

  function automatic void model_reset();
    m_play = -1; m_left = 0; m_gap = 0; m_pend = '0; m_grant = '0;
  endfunction

  function automatic void model_step(bit e, bit s, logic [NR-1:0] r);
    int top;
    int old;
    bit was_play;
    m_grant = '0;
    if (!e) begin
      m_play = -1; m_left = 0; m_gap = 0; m_pend = '0;
      return;
    end
    top = -1;
    for (int i = 0; i < NR; i++) if (m_pend[i] || r[i]) top = i;
    m_pend   = m_pend | r;
    old      = m_play;
    was_play = (m_play >= 0);
    if ((was_play && (top > m_play || r[m_play] == 1'b1)) ||
        (!was_play && m_gap == 0 && top >= 0)) begin
      m_play       = top;
      m_left       = len_tab[top];
      m_pend[top]  = 1'b0;
      m_grant[top] = 1'b1;
    end else if (was_play && s) begin
      m_left--;
      if (m_left == 0) begin
        m_play = -1;
        m_gap  = GAPF;
      end
    end else if (m_gap > 0 && s) begin
      m_gap--;
    end
`ifndef SOUND_QUEUE_EN
    if (was_play) for (int i = 0; i < old; i++) m_pend[i] = 1'b0;
`endif
  endfunction

  function automatic sound_t exp_snd();
    return (m_play >= 0) ? snd_tab[m_play] : SND_NONE;
  endfunction

  function automatic bit exp_busy();
    return (m_play >= 0) || (m_gap > 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_snd"},   32'(sound_type), 32'(exp_snd()));
    chk({tag, "_grant"}, 32'(grant),      32'(m_grant));
    chk({tag, "_busy"},  32'(busy),       32'(exp_busy()));
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge.
  task automatic step(input bit e, input bit s, input logic [NR-1:0] r);
    en = e; frame_stb = s; req = r;
    @(posedge clk);
    model_step(e, s, r);
    @(negedge clk);
    chk_model("model");
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; frame_stb = 1'b0;
    #1;
    model_reset();
    chk_model("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit            e;
    bit            s;
    logic [NR-1:0] r;
    sound_t        snd;
    logic [NR-1:0] g;
    bit            b;
  } vec_t;

  vec_t tv [15];

  initial begin
    sound_t        q_snd;
    logic [NR-1:0] q_g;
    tv[0] = '{1'b1, 1'b0, 4'b0001, SND_CHOMP, 4'b0001, 1'b1};
    for (int i = 1; i <= 7; i++)
      tv[i] = '{1'b1, 1'b1, 4'b0000, SND_CHOMP, 4'b0000, 1'b1};
    tv[8]  = '{1'b1, 1'b1, 4'b0000, SND_NONE,  4'b0000, 1'b1};
    tv[9]  = '{1'b1, 1'b1, 4'b0000, SND_NONE,  4'b0000, 1'b0};
    tv[10] = '{1'b1, 1'b0, 4'b0000, SND_NONE,  4'b0000, 1'b0};
    tv[11] = '{1'b1, 1'b0, 4'b0001, SND_CHOMP, 4'b0001, 1'b1};
    tv[12] = '{1'b1, 1'b1, 4'b0000, SND_CHOMP, 4'b0000, 1'b1};
    tv[13] = '{1'b1, 1'b1, 4'b0100, SND_DEATH, 4'b0100, 1'b1};
    tv[14] = '{1'b1, 1'b0, 4'b0001, SND_DEATH, 4'b0000, 1'b1};

    rst = 1'b1; en = 1'b0; frame_stb = 1'b0; req = '0;
    @(negedge clk);
    chk("reset_snd",   32'(sound_type), 32'(SND_NONE));
    chk("reset_grant", 32'(grant),      32'd0);
    chk("reset_busy",  32'(busy),       32'd0);
    rst = 1'b0;
    model_reset();

    // Basic play, gap, preempt with coincident frame strobe
    for (int i = 0; i < 15; i++) begin
      step(tv[i].e, tv[i].s, tv[i].r);
      chk($sformatf("tv%0d_snd", i),   32'(sound_type), 32'(tv[i].snd));
      chk($sformatf("tv%0d_grant", i), 32'(grant),      32'(tv[i].g));
      chk($sformatf("tv%0d_busy", i),  32'(busy),       32'(tv[i].b));
    end

    // DEATH preempt reloaded to a full 90 frames
    for (int f = 1; f <= 89; f++) begin
      step(1'b1, 1'b1, '0);
      chk($sformatf("death_f%0d", f), 32'(sound_type), 32'(SND_DEATH));
    end
    step(1'b1, 1'b1, '0);
    chk("death_end_snd",  32'(sound_type), 32'(SND_NONE));
    chk("death_end_busy", 32'(busy),       32'd1);
    step(1'b1, 1'b1, '0);
    chk("gap_end_busy", 32'(busy), 32'd0);
`ifdef SOUND_QUEUE_EN
    q_snd = SND_CHOMP; q_g = 4'b0001;
`else
    q_snd = SND_NONE;  q_g = 4'b0000;
`endif
    step(1'b1, 1'b0, '0);
    chk("queued_snd",   32'(sound_type), 32'(q_snd));
    chk("queued_grant", 32'(grant),      32'(q_g));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    pulse_reset();

    // Retrigger every 5 frames keeps CHOMP alive without a gap
    step(1'b1, 1'b0, 4'b0001);
    for (int f = 1; f <= 20; f++) begin
      step(1'b1, 1'b1, (f % 5 == 0) ? 4'b0001 : 4'b0000);
      chk($sformatf("retrig_snd%0d", f), 32'(sound_type), 32'(SND_CHOMP));
      chk($sformatf("retrig_g%0d", f), 32'(grant),
          (f % 5 == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, '0);

    // Disable mid-INTRO with a lower request outstanding
    step(1'b1, 1'b0, 4'b1000);
    chk("intro_grant", 32'(grant), 32'b1000);
    step(1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("en_off_snd",  32'(sound_type), 32'(SND_NONE));
    chk("en_off_busy", 32'(busy),       32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      chk($sformatf("en_on_busy%0d", i), 32'(busy), 32'd0);
    end

    // Reset mid-PLAY coinciding with a top-priority request
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b1, '0);
    rst = 1'b1; req = 4'b1000;
    #1;
    chk("arst_snd",   32'(sound_type), 32'(SND_NONE));
    chk("arst_grant", 32'(grant),      32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_grant", 32'(grant), 32'd0);
    chk("rst_hold_busy",  32'(busy),  32'd0);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, '0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Random traffic against the reference model
    for (int c = 0; c < 5000; c++) begin
      logic [NR-1:0] r;
      for (int b = 0; b < NR; b++) r[b] = ($urandom_range(99) < 4);
      if ($urandom_range(799) == 0) pulse_reset();
      step($urandom_range(99) < 97, $urandom_range(99) < 35, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of sound requesters; index NUM_REQ-1 is highest priority.
REQ-002 SHALL have parameter GAP_FRAMES, default 1, number of silent frames inserted after a sound completes; 0 means no gap.
REQ-003 SHALL have ports clk in 1, the single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst in 1, asynchronous active-high reset.
REQ-005 SHALL have port en in 1, audio enable; low mutes and flushes all requests.
REQ-006 SHALL have port frame_stb in 1, one-cycle pulse per video frame, used as duration time base.
REQ-007 SHALL have port req in NUM_REQ, per-requester sound request; a pulse or a held level are both legal.
REQ-008 SHALL have port sound_type out sound_t, sound currently driven to the audio player.
REQ-009 SHALL have port grant out NUM_REQ, one-hot one-cycle pulse marking the requester just started or restarted.
REQ-010 SHALL have port busy out 1, high whenever state is not IDLE.

Function
REQ-011 SHALL latch each req bit into a pending bit; pending clears only on grant of that index, or as stated in REQ-019/020.
REQ-012 SHALL compute candidate = highest index set in (req | pending), combinationally.
REQ-013 SHALL implement states IDLE, PLAY, GAP; sound_type = SND_NONE in IDLE and GAP.
REQ-014 IDLE: candidate exists -> PLAY on next edge; load frame counter with SOUND_FRAMES[candidate]; grant[candidate] high that cycle; sound_type = SOUND_MAP[candidate]; latency from req to sound_type is exactly 1 clk.
REQ-015 PLAY: counter decrements by 1 on each frame_stb; on frame_stb with counter == 1 -> GAP (counter loaded with GAP_FRAMES), or -> IDLE directly if GAP_FRAMES == 0.
REQ-016 PLAY: candidate index > current index -> preempt on next edge: reload counter, update sound_type, pulse grant; preemption wins over a simultaneous frame_stb.
REQ-017 PLAY: req of current index -> retrigger: reload counter, pulse grant, sound_type unchanged.
REQ-018 GAP: counter decrements on frame_stb; reaching 0 -> IDLE; a request of any index during GAP is held pending, never started from GAP.
REQ-019 en low: next edge forces IDLE, clears all pending, ignores req, grant low; en high resumes from IDLE.
REQ-020 Lower-priority request while PLAY: behaviour per REQ-027.
REQ-021 Counter width SHALL be $clog2 of max(SOUND_FRAMES, GAP_FRAMES)+1; no wrap below 0.

Reset
REQ-022 rst SHALL asynchronously force state IDLE, counter 0, pending all 0.
REQ-023 Reset values SHALL be sound_type SND_NONE, grant 0, busy 0.
REQ-024 rst asserted mid-PLAY SHALL abort the sound with no grant pulse; the first edge after release evaluates only new req.

Configuration
REQ-025 Macro SOUND_QUEUE_EN SHALL select lower-priority handling.
REQ-026 With SOUND_QUEUE_EN defined: lower-priority requests stay pending and play after the current sound and gap, highest first.
REQ-027 Without SOUND_QUEUE_EN: a request whose index is lower than the playing index clears its pending bit on the next edge and is discarded.

Structure
REQ-028 Shared package params SHALL hold sound_t (SND_NONE, SND_CHOMP, SND_EAT_GHOST, SND_DEATH, SND_INTRO), SOUND_MAP (index 0..3 -> CHOMP, EAT_GHOST, DEATH, INTRO) and SOUND_FRAMES (8, 30, 90, 240).
REQ-029 One sub-module, prio_encoder (NUM_REQ -> index plus valid), SHALL be used for candidate selection; everything else is inline.

Verification
REQ-030 req[0] pulse, GAP_FRAMES=1 -> grant=0001 one clk later, SND_CHOMP for 8 frame_stb, SND_NONE 1 frame, busy drops after the 9th frame_stb.
REQ-031 SND_CHOMP playing, req[2] pulse -> next clk grant=0100, SND_DEATH, counter=90, even when frame_stb coincides.
REQ-032 SND_DEATH playing, req[0] pulse -> with SOUND_QUEUE_EN CHOMP starts after DEATH plus gap; without it CHOMP never plays.
REQ-033 req[0] re-pulsed every 5 frames -> SND_CHOMP held continuously, grant=0001 on each pulse, no GAP entered.
REQ-034 en low mid-INTRO with req[1] pending -> IDLE, SND_NONE next clk; en high with no new req -> stays IDLE.
REQ-035 rst asserted mid-PLAY and at the same edge as req[3] -> outputs at reset values immediately; no grant while rst is high.
